// File: rtl/module_seg_capture.sv
// Observer for a multiplexed four-digit 7-segment bus. It decodes the settled glyphs back into a 16-bit value.
// Optional saturating error counter is built only when SEG_CAPTURE_ERRCNT_EN is defined.
module module_seg_capture #(
    parameter int unsigned SETTLE         = 4,
    parameter int unsigned TIMEOUT        = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  transis,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        changed,
    output logic        glyph_err,
    output logic        overlap_err,
    output logic        stale,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLING,
        ST_LATCHED
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       is_blank;
        logic [3:0] nibble;
    } glyph_t;

    localparam logic [6:0]  SEG_IDLE   = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0]  AN_IDLE    = {4{AN_ACTIVE_LOW}};
    localparam logic [7:0]  SETTLE_M1  = 8'(SETTLE - 1);
    localparam logic [23:0] TIMEOUT_LV = 24'(TIMEOUT);

    // Patterns are active-high, bit order g..a.
    function automatic glyph_t decode_glyph(input logic [6:0] pat);
        glyph_t g;
        g = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h0};
        case (pat)
            7'h3F: g.nibble = 4'h0;
            7'h06: g.nibble = 4'h1;
            7'h5B: g.nibble = 4'h2;
            7'h4F: g.nibble = 4'h3;
            7'h66: g.nibble = 4'h4;
            7'h6D: g.nibble = 4'h5;
            7'h7D: g.nibble = 4'h6;
            7'h07: g.nibble = 4'h7;
            7'h7F: g.nibble = 4'h8;
            7'h6F: g.nibble = 4'h9;
            7'h77: g.nibble = 4'hA;
            7'h7C: g.nibble = 4'hB;
            7'h39: g.nibble = 4'hC;
            7'h5E: g.nibble = 4'hD;
            7'h79: g.nibble = 4'hE;
            7'h71: g.nibble = 4'hF;
            7'h00: g.is_blank = 1'b1;
            default: g.legal = 1'b0;
        endcase
        return g;
    endfunction

    logic [6:0]  seg_s1_q, seg_s2_q;
    logic [3:0]  an_s1_q, an_s2_q;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        one_hot, multi;
    logic [1:0]  dig_idx;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  dig_q, dig_d;
    logic [6:0]  pat_q, pat_d;
    logic        same_sample;
    logic        latch;
    glyph_t      glyph;

    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  sblank_q, sblank_d;
    logic [3:0]  seen_q, seen_d;
    logic        frame_fire;

    logic [15:0] value_q, value_d;
    logic [3:0]  blank_q, blank_d;
    logic        frame_valid_q, frame_valid_d;
    logic        changed_q, changed_d;
    logic        glyph_err_q, glyph_err_d;
    logic        overlap_err_q, overlap_err_d;
    logic        multi_q;
    logic [23:0] stale_cnt_q, stale_cnt_d;

    // Two-flop synchronizer; reset to the bus's inactive level so nothing looks lit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_s1_q <= SEG_IDLE;
            seg_s2_q <= SEG_IDLE;
            an_s1_q  <= AN_IDLE;
            an_s2_q  <= AN_IDLE;
        end else begin
            // NOTE: non-blocking assignments let each flop take the previous stage's old value, forming a real 2-stage pipe.
            seg_s1_q <= seg;
            seg_s2_q <= seg_s1_q;
            an_s1_q  <= transis;
            an_s2_q  <= an_s1_q;
        end
    end

    assign seg_n = seg_s2_q ^ SEG_IDLE;
    assign an_n  = an_s2_q ^ AN_IDLE;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        one_hot = 1'b1;
        dig_idx = 2'd0;
        case (an_n)
            4'b0001: dig_idx = 2'd0;
            4'b0010: dig_idx = 2'd1;
            4'b0100: dig_idx = 2'd2;
            4'b1000: dig_idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    assign multi       = (an_n != 4'b0000) && !one_hot;
    assign same_sample = (dig_idx == dig_q) && (seg_n == pat_q);

    // Settle FSM: a digit must hold the same (index, pattern) for SETTLE cycles before it latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        pat_d   = pat_q;
        latch   = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (one_hot) begin
                    state_d = ST_SETTLING;
                    cnt_d   = 8'd1;
                    dig_d   = dig_idx;
                    pat_d   = seg_n;
                end
            end
            ST_SETTLING: begin
                if (!one_hot) begin
                    state_d = ST_WAIT;
                end else if (!same_sample) begin
                    cnt_d = 8'd1;
                    dig_d = dig_idx;
                    pat_d = seg_n;
                end else if (cnt_q == SETTLE_M1) begin
                    latch   = 1'b1;
                    state_d = ST_LATCHED;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_LATCHED: begin
                if (!one_hot) begin
                    state_d = ST_WAIT;
                end else if (!same_sample) begin
                    state_d = ST_SETTLING;
                    cnt_d   = 8'd1;
                    dig_d   = dig_idx;
                    pat_d   = seg_n;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    assign glyph      = decode_glyph(pat_q);
    assign frame_fire = (seen_q == 4'hF);

    // Shadow assembly and frame publication; a latch in the closing cycle already belongs to the next frame.
    always_comb begin
        shadow_d      = shadow_q;
        sblank_d      = sblank_q;
        seen_d        = frame_fire ? 4'h0 : seen_q;
        glyph_err_d   = 1'b0;
        value_d       = value_q;
        blank_d       = blank_q;
        frame_valid_d = frame_fire;
        changed_d     = 1'b0;
        if (latch) begin
            if (glyph.legal) begin
                shadow_d[{dig_q, 2'b00} +: 4] = glyph.nibble;
                sblank_d[dig_q]               = glyph.is_blank;
                seen_d[dig_q]                 = 1'b1;
            end else begin
                glyph_err_d = 1'b1;
            end
        end
        if (frame_fire) begin
            value_d   = shadow_q;
            blank_d   = sblank_q;
            changed_d = ({sblank_q, shadow_q} != {blank_q, value_q});
        end
    end

    assign overlap_err_d = multi && !multi_q;
    assign stale_cnt_d   = latch ? 24'd0 : (&stale_cnt_q ? stale_cnt_q : stale_cnt_q + 24'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_WAIT;
            cnt_q         <= 8'd0;
            dig_q         <= 2'd0;
            pat_q         <= 7'd0;
            // NOTE: the shadow store is reset deliberately: a reset must discard a half-assembled frame.
            shadow_q      <= 16'h0000;
            sblank_q      <= 4'h0;
            seen_q        <= 4'h0;
            value_q       <= 16'h0000;
            blank_q       <= 4'h0;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            glyph_err_q   <= 1'b0;
            overlap_err_q <= 1'b0;
            multi_q       <= 1'b0;
            stale_cnt_q   <= 24'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            pat_q         <= pat_d;
            shadow_q      <= shadow_d;
            sblank_q      <= sblank_d;
            seen_q        <= seen_d;
            value_q       <= value_d;
            blank_q       <= blank_d;
            frame_valid_q <= frame_valid_d;
            changed_q     <= changed_d;
            glyph_err_q   <= glyph_err_d;
            overlap_err_q <= overlap_err_d;
            multi_q       <= multi;
            stale_cnt_q   <= stale_cnt_d;
        end
    end

    assign value       = value_q;
    assign blank       = blank_q;
    assign frame_valid = frame_valid_q;
    assign changed     = changed_q;
    assign glyph_err   = glyph_err_q;
    assign overlap_err = overlap_err_q;
    assign stale       = (stale_cnt_q >= TIMEOUT_LV);

`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic [8:0] err_sum;

    // Both error pulses may land in the same cycle, so the increment is 0..2 before saturation.
    assign err_sum = {1'b0, err_cnt_q} + {7'd0, glyph_err_q} + {7'd0, overlap_err_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_module_seg_capture.sv
// Scoreboard bench for module_seg_capture: stimulus queues expected frames, a monitor pops them on frame_valid.
module tb_module_seg_capture;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  blank;
        logic        changed;
    } frame_t;

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  transis;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        changed;
    logic        glyph_err;
    logic        overlap_err;
    logic        stale;
    logic [7:0]  err_cnt;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     glyph_seen = 0;
    int     overlap_seen = 0;

    module_seg_capture #(
        .SETTLE        (4),
        .TIMEOUT       (64),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .transis    (transis),
        .value      (value),
        .blank      (blank),
        .frame_valid(frame_valid),
        .changed    (changed),
        .glyph_err  (glyph_err),
        .overlap_err(overlap_err),
        .stale      (stale),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every frame_valid pops one expected frame; pulses are tallied for later checks.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    frame_t e;
                    e = exp_q.pop_front();
                    check("frame_value", {16'd0, value}, {16'd0, e.value});
                    check("frame_blank", {28'd0, blank}, {28'd0, e.blank});
                    check("frame_changed", {31'd0, changed}, {31'd0, e.changed});
                end
            end
            if (glyph_err) glyph_seen++;
            if (overlap_err) overlap_seen++;
        end
    end

    // Drive digit d with an active-high pattern (bus is active-low) for cyc cycles.
    task automatic show(input int d, input logic [6:0] pat_hi, input int cyc);
        logic [3:0] one;
        one = 4'b0001;
        transis = ~(one << d);
        seg = ~pat_hi;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cyc);
        transis = 4'hF;
        seg = 7'h7F;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] b, input logic c);
        frame_t f;
        f.value = v;
        f.blank = b;
        f.changed = c;
        exp_q.push_back(f);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        seg = 7'h7F;
        transis = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", {16'd0, value}, 32'd0);
        check("rst_blank", {28'd0, blank}, 32'd0);
        check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_changed", {31'd0, changed}, 32'd0);
        check("rst_glyph_err", {31'd0, glyph_err}, 32'd0);
        check("rst_overlap_err", {31'd0, overlap_err}, 32'd0);
        check("rst_stale", {31'd0, stale}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b1;
        idle(4);

        // Frame decode: digits 0..3 show 1,2,3,4.
        push(16'h4321, 4'h0, 1'b1);
        show(0, 7'h06, 10); show(1, 7'h5B, 10); show(2, 7'h4F, 10); show(3, 7'h66, 10);
        drain("drain_first_frame");

        // Same scan again, then digit 2 switched to F.
        push(16'h4321, 4'h0, 1'b0);
        show(0, 7'h06, 10); show(1, 7'h5B, 10); show(2, 7'h4F, 10); show(3, 7'h66, 10);
        drain("drain_repeat_frame");
        push(16'h4F21, 4'h0, 1'b1);
        show(0, 7'h06, 10); show(1, 7'h5B, 10); show(2, 7'h71, 10); show(3, 7'h66, 10);
        drain("drain_changed_frame");

        // Settling: digit 1 glitches 2<->3 and must not latch; holding 3 completes the frame.
        show(0, 7'h06, 10); show(2, 7'h71, 10); show(3, 7'h66, 10);
        for (int i = 0; i < 6; i++) begin
            show(1, (i % 2 == 0) ? 7'h5B : 7'h4F, 2);
        end
        idle(12);
        check("no_frame_during_glitch", {31'd0, frame_valid}, 32'd0);
        push(16'h4F31, 4'h0, 1'b1);
        show(1, 7'h4F, 6);
        idle(6);
        drain("drain_settled_frame");
        check("settled_nibble", {28'd0, value[7:4]}, 32'd3);

        // Errors: illegal glyph, then two digits enabled together.
        show(0, 7'h01, 10);
        idle(6);
        transis = 4'b0011;
        seg = 7'h7F;
        repeat (10) @(posedge clk);
        #1;
        idle(6);
        check("glyph_err_pulses", glyph_seen, 32'd1);
        check("overlap_err_pulses", overlap_seen, 32'd1);
`ifdef SEG_CAPTURE_ERRCNT_EN
        check("err_cnt_after_errors", {24'd0, err_cnt}, 32'd2);
`else
        check("err_cnt_after_errors", {24'd0, err_cnt}, 32'd0);
`endif

        // Blank digit 3, then idle long enough to go stale.
        push(16'h0321, 4'b1000, 1'b1);
        show(0, 7'h06, 10); show(1, 7'h5B, 10); show(2, 7'h4F, 10); show(3, 7'h00, 10);
        drain("drain_blank_frame");
        check("stale_low_after_latch", {31'd0, stale}, 32'd0);
        idle(80);
        check("stale_high_when_idle", {31'd0, stale}, 32'd1);
        show(0, 7'h06, 10);
        check("stale_cleared_by_latch", {31'd0, stale}, 32'd0);

        // Reset mid-frame: digits 0,1,2 latched, then reset discards them.
        show(1, 7'h5B, 10); show(2, 7'h4F, 10);
        idle(1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_value", {16'd0, value}, 32'd0);
        check("midrst_blank", {28'd0, blank}, 32'd0);
        check("midrst_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("midrst_stale", {31'd0, stale}, 32'd0);
        check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b1;
        idle(4);
        show(3, 7'h7F, 10);
        idle(20);
        check("no_frame_after_rst_partial", exp_q.size(), 32'd0);
        push(16'h8765, 4'h0, 1'b1);
        show(0, 7'h6D, 10); show(1, 7'h7D, 10); show(2, 7'h07, 10); show(3, 7'h7F, 10);
        drain("drain_post_rst_frame");
        idle(10);
        check("final_glyph_err_pulses", glyph_seen, 32'd1);
        check("final_overlap_err_pulses", overlap_seen, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/module_seg_capture.md
# module_seg_capture

Observer for the multiplexed four-digit 7-segment bus (`seg`/`transis`) driven by the display path of `module_top_general`. It samples the strobed segment and anode lines, waits for each digit's pattern to settle, and decodes each glyph back to a hex nibble. It then reassembles the full 16-bit displayed value and reports it with a one-cycle frame strobe. It is used for self-checking in benches and for on-board readback of what the display is actually showing.

## Interface
Parameters:
- `SETTLE`, 4: consecutive stable cycles required, with one digit enabled, before that digit is latched. Legal range is 2..255.
- `TIMEOUT`, 100000: cycles without any latch before `stale` asserts. Legal range is 16..2^24-1.
- `SEG_ACTIVE_LOW`, 1: 1 means a lit segment reads 0 on `seg`.
- `AN_ACTIVE_LOW`, 1: 1 means an enabled digit reads 0 on `transis`.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `seg` input 7: segment lines; `seg[0]`=a … `seg[6]`=g.
- `transis` input 4: digit enables; `transis[i]` selects `value[4i+3:4i]`.
- `value` output 16: last complete decoded frame.
- `blank` output 4: per-digit flag; `blank[i]`=1 means digit i was all-segments-off in the last frame, and its nibble reads 0.
- `frame_valid` output 1: one-cycle pulse when `value`/`blank` update.
- `changed` output 1: one-cycle pulse, coincident with `frame_valid`, when `{blank,value}` differs from the previous frame.
- `glyph_err` output 1: one-cycle pulse when a settled pattern is not a legal glyph.
- `overlap_err` output 1: one-cycle pulse on the first cycle that more than one digit is enabled.
- `stale` output 1: high while no digit has latched for `TIMEOUT` cycles.
- `err_cnt` output 8: saturating error counter (see Configuration).

## Operation
- **Input synchronizer:** `seg` and `transis` pass through a 2-flop synchronizer. Polarity is normalized to active-high after synchronization.
- **Digit qualification:**
  - Qualified digit = normalized `transis` is one-hot. The index d comes from the one-hot position.
  - Zero enables: idle.
  - More than one enable: invalid. `overlap_err` pulses on the rising edge of the invalid condition only.
- **Settle FSM** (states WAIT, SETTLING, LATCHED):
  - WAIT → SETTLING on a qualified digit; the settle counter loads 1.
  - SETTLING: while (d, seg) are unchanged the counter increments. When it reaches `SETTLE`, latch and go to LATCHED.
  - SETTLING: any change in d or seg restarts the counter at 1 and stays in SETTLING. Loss of qualification goes to WAIT.
  - LATCHED: no further latch for the same digit. A change in d or seg → SETTLING; loss of qualification → WAIT.
- **Latch:**
  - Decode pattern (active-high, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Pattern 00 = blank.
  - Legal glyph: shadow[d] ← nibble (0 if blank), sblank[d] ← blank flag, seen[d] ← 1.
  - Illegal glyph: `glyph_err` pulses and shadow/seen are untouched.
- **Frame:**
  - When `seen`=4'hF, on the next cycle: `value`←shadow, `blank`←sblank, `frame_valid`=1, `changed` per the compare, and seen←0.
  - A digit re-latched before the frame closes overwrites its shadow (last value wins).
- **Stale:** a 24-bit counter clears on every latch and otherwise increments, saturating. `stale`=1 when the count ≥ `TIMEOUT`.

## Timing
- Reset values:
  - `value`=0, `blank`=0, `frame_valid`=0, `changed`=0, `glyph_err`=0, `overlap_err`=0, `stale`=0, `err_cnt`=0.
  - FSM in WAIT, seen=0, synchronizer flops = inactive level.
- Input to FSM latency is 2 cycles (synchronizer).
- A digit latches `SETTLE` cycles after its first stable synchronized cycle. For example, with `SETTLE`=4 and inputs stable from cycle t, the latch happens at t+2+3, registered on t+6.
- `frame_valid` fires 1 cycle after the fourth distinct digit latches.
- All pulses are exactly one cycle wide. `frame_valid` and `glyph_err` can coincide.
- Reset asserted mid-frame discards the shadow and seen state. The first `frame_valid` after reset requires all four digits again.

## Configuration
- `SEG_CAPTURE_ERRCNT_EN` defined:
  - `err_cnt` counts `glyph_err` plus `overlap_err` events.
  - It saturates at 8'hFF; on a cycle where both events occur it adds 2, still saturating.
- Not defined: `err_cnt` is tied to 8'h00 and no counter logic is built. All other behaviour is identical.

## Test plan
- **Frame decode:** active-low scan of digits 0..3 with patterns for 1,2,3,4, each held 10 cycles, `SETTLE`=4 → `frame_valid` pulses once with `value`=16'h4321, `blank`=0, `changed`=1.
- **Repeat and change:** the same scan repeated → `frame_valid` with `changed`=0. Then digit 2 switched to pattern F → next frame has `value`=16'h4F21 and `changed`=1.
- **Settling:** digit 1 glitched between 2 and 3 every 2 cycles and then held at 3 for 6 cycles → no latch during the glitch; `value[7:4]`=3.
- **Errors:**
  - Digit 0 holds illegal pattern 7'h01 (active-high) → `glyph_err` pulse and no `frame_valid`.
  - `transis`=4'b0011 (active-low) → one `overlap_err` pulse.
  - With `SEG_CAPTURE_ERRCNT_EN`, these give `err_cnt`=2. Without it, `err_cnt` stays 0.
- **Blank and stale:** digit 3 all-off → `blank`=4'b1000 and `value[15:12]`=0. Then `transis` held idle for `TIMEOUT`=64 cycles → `stale`=1, which clears on the next latch.
- **Reset mid-frame:** after 3 digits have latched, pulse `rst` low → all outputs return to reset values. A full 4-digit scan is required for the next `frame_valid`.
